// File: rtl/memwb_pipe_buf.sv
// MEM/WB stage buffer: DEPTH-entry circular FIFO, write-back mux, R0 write masking, forwarding tap, bubble counter.
// Latency: an entry captured on a falling CLK edge into an empty buffer is on out* right after that edge.
// Backpressure: in_ready = count < DEPTH from registered count only; when full, input is ignored even on a pop edge.
module memwb_pipe_buf #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16,
    parameter int MASK_R0 = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [REG_AW-1:0] Wreg_addr,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic              Branch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outMemRdata,
    output logic [DATA_W-1:0] outALU_result,
    output logic [DATA_W-1:0] outWdata,
    output logic [REG_AW-1:0] outWreg_addr,
    output logic              outRegWrite,
    output logic              outMemToReg,
    output logic              outBranch,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BW = $clog2(DEPTH + 1);
    localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] mem_rdata;
        logic [DATA_W-1:0] alu_result;
        logic [REG_AW-1:0] wreg_addr;
        logic              reg_write;
        logic              mem_to_reg;
        logic              branch;
    } entry_t;

    entry_t              entry_q [DEPTH];
    entry_t              cap_dat;
    entry_t              head_dat;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [CNT_BW-1:0]   count_q;
    logic [CNT_W-1:0]    bubble_q;
    logic                push;
    logic                pop;
    logic                bubble;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign bubble    = out_ready & ~out_valid;

    // Writes to r0 are dropped at capture so neither write-back nor forwarding ever sees them.
    always_comb begin
        cap_dat            = '0;
        cap_dat.mem_rdata  = MemRdata;
        cap_dat.alu_result = ALU_result;
        cap_dat.wreg_addr  = Wreg_addr;
        cap_dat.reg_write  = RegWrite & ~((MASK_R0 != 0) && (Wreg_addr == '0));
        cap_dat.mem_to_reg = MemToReg;
        cap_dat.branch     = Branch;
    end

    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= cap_dat;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_BW'(1);
                2'b01:   count_q <= count_q - CNT_BW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bubble_q <= '0;
        end else if (bubble && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    // Empty buffer presents all-zero fields rather than stale storage.
    assign head_dat      = out_valid ? entry_q[rd_ptr_q] : '0;

    assign outMemRdata   = head_dat.mem_rdata;
    assign outALU_result = head_dat.alu_result;
    assign outWdata      = head_dat.mem_to_reg ? head_dat.mem_rdata : head_dat.alu_result;
    assign outWreg_addr  = head_dat.wreg_addr;
    assign outRegWrite   = head_dat.reg_write & out_valid;
    assign outMemToReg   = head_dat.mem_to_reg;
    assign outBranch     = head_dat.branch & out_valid;
    assign fwd_valid     = out_valid & outRegWrite;
    assign fwd_addr      = outWreg_addr;
    assign fwd_data      = outWdata;
    assign bubble_cnt    = bubble_q;

endmodule

// File: tb/tb_memwb_pipe_buf.sv
// Directed bench for memwb_pipe_buf (DEPTH=2, CNT_W=4) with a queue scoreboard of expected head entries.
module tb_memwb_pipe_buf;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic        in_valid, in_ready, flush;
    logic [31:0] MemRdata, ALU_result;
    logic [4:0]  Wreg_addr;
    logic        RegWrite, MemToReg, Branch;
    logic        out_valid, out_ready;
    logic [31:0] outMemRdata, outALU_result, outWdata, fwd_data;
    logic [4:0]  outWreg_addr, fwd_addr;
    logic        outRegWrite, outMemToReg, outBranch, fwd_valid;
    logic [3:0]  bubble_cnt;

    typedef struct {
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  addr;
        logic        rw;
        logic        m2r;
        logic        br;
    } exp_t;

    exp_t sbq[$];
    int   bmodel = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    memwb_pipe_buf #(.DATA_W(32), .REG_AW(5), .DEPTH(2), .CNT_W(4), .MASK_R0(1)) dut (
        .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .MemRdata(MemRdata), .ALU_result(ALU_result), .Wreg_addr(Wreg_addr),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .Branch(Branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .outMemRdata(outMemRdata), .outALU_result(outALU_result), .outWdata(outWdata),
        .outWreg_addr(outWreg_addr), .outRegWrite(outRegWrite), .outMemToReg(outMemToReg),
        .outBranch(outBranch), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check current outputs against the model, then apply one falling edge with the given inputs.
    task automatic cyc(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] addr,
                       input logic rw, input logic m2r, input logic br);
        exp_t        e;
        logic [31:0] wd;
        int          old_n;
        in_valid = iv; out_ready = ordy; flush = fl;
        MemRdata = mem; ALU_result = alu; Wreg_addr = addr;
        RegWrite = rw; MemToReg = m2r; Branch = br;
        chk("in_ready", 32'(in_ready), 32'(sbq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(sbq.size() > 0));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(bmodel));
        if (sbq.size() > 0) begin
            e  = sbq[0];
            wd = e.m2r ? e.mem : e.alu;
            chk("outWdata", outWdata, wd);
            chk("outMemRdata", outMemRdata, e.mem);
            chk("outALU_result", outALU_result, e.alu);
            chk("outWreg_addr", 32'(outWreg_addr), 32'(e.addr));
            chk("outRegWrite", 32'(outRegWrite), 32'(e.rw));
            chk("outMemToReg", 32'(outMemToReg), 32'(e.m2r));
            chk("outBranch", 32'(outBranch), 32'(e.br));
            chk("fwd_valid", 32'(fwd_valid), 32'(e.rw));
            chk("fwd_addr", 32'(fwd_addr), 32'(e.addr));
            chk("fwd_data", fwd_data, wd);
        end else begin
            chk("empty_wdata", outWdata, 32'h0);
            chk("empty_wreg_addr", 32'(outWreg_addr), 32'h0);
            chk("empty_regwrite", 32'(outRegWrite), 32'h0);
            chk("empty_branch", 32'(outBranch), 32'h0);
            chk("empty_fwd_valid", 32'(fwd_valid), 32'h0);
        end
        @(negedge CLK);
        old_n = sbq.size();
        if (ordy && old_n == 0) bmodel = (bmodel == 15) ? 15 : bmodel + 1;
        if (fl) begin
            sbq.delete();
        end else begin
            if (ordy && old_n > 0) void'(sbq.pop_front());
            if (iv && old_n < 2) begin
                e.mem = mem; e.alu = alu; e.addr = addr;
                e.rw = rw && (addr != 5'd0); e.m2r = m2r; e.br = br;
                sbq.push_back(e);
            end
        end
        #2;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, ordy, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RSTn = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        MemRdata = '0; ALU_result = '0; Wreg_addr = '0;
        RegWrite = 1'b0; MemToReg = 1'b0; Branch = 1'b0;
        #1 RSTn = 1'b0;
        @(negedge CLK); #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_bubble", 32'(bubble_cnt), 32'h0);
        RSTn = 1'b1;

        // Single pass with write-back draining immediately
        cyc(1'b1, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("pass_wdata", outWdata, 32'h0000_1234);
        chk("pass_fwd_addr", 32'(fwd_addr), 32'd5);
        idle(1'b1);
        idle(1'b1);

        // Stall until full; third entry must be rejected
        cyc(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0010, 5'd3, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_00AB, 5'd7, 1'b1, 1'b0, 1'b1);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'h0000_00CD, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("full_head_wdata", outWdata, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_00EF, 5'd10, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Simultaneous push and pop at count 1
        cyc(1'b1, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 5'd11, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'h3333_3333, 32'h4444_4444, 5'd12, 1'b0, 1'b0, 1'b1);
        chk("pp_head_alu", outALU_result, 32'h4444_4444);
        idle(1'b1);
        idle(1'b1);

        // Flush at count 2 drops the incoming entry too
        cyc(1'b1, 1'b0, 1'b0, 32'h5555_5555, 32'h6666_6666, 5'd13, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h7777_7777, 32'h8888_8888, 5'd14, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h9999_9999, 32'hAAAA_AAAA, 5'd15, 1'b1, 1'b0, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        idle(1'b1);

        // Asynchronous reset with two entries buffered
        cyc(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0000_0042, 5'd16, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0043, 5'd17, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        RSTn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_wdata", outWdata, 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        chk("mid_rst_bubble", 32'(bubble_cnt), 32'h0);
        sbq.delete();
        bmodel = 0;
        @(negedge CLK); #2;
        RSTn = 1'b1;
        idle(1'b0);

        // r0 write masking, then bubble counter saturation
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0099, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("r0_regwrite", 32'(outRegWrite), 32'h0);
        chk("r0_fwd_valid", 32'(fwd_valid), 32'h0);
        for (int i = 0; i < 20; i++) idle(1'b1);
        chk("bubble_sat", 32'(bubble_cnt), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
